// File: rtl/day11_down_timer_pkg.sv
// rtl/day11_down_timer_pkg.sv - shared types and defaults for the day11 down timer
//
// Purpose : control-state encoding and default width for day11_down_timer.
// Contents: state_t       - IDLE / RUN / PAUSE
//           DEFAULT_WIDTH - default bit width of count and reload registers
package day11_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/day11_down_timer.sv
// rtl/day11_down_timer.sv - loadable one-shot / auto-reload down-counter timer
//
// Purpose : counts a programmed value down to zero, pulses tc_o for one cycle
//           when the count first reaches zero, then stops (one-shot) or
//           reloads (auto-reload). A start/stop FSM gates the datapath.
// Ports   : clk         rising-edge clock
//           reset       asynchronous active-low reset
//           load_i      load request
//           load_val_i  value captured on load_i
//           start_i     start / resume request
//           stop_i      pause request (wins over start_i)
//           mode_i      0 = one-shot, 1 = auto-reload (sampled at count 0)
//           count_o     current count (registered)
//           tc_o        terminal-count pulse (registered, one cycle)
//           busy_o      high while in RUN
module day11_down_timer
    import day11_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             busy_o
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_q, count_nxt;
    logic [WIDTH-1:0] reload_q, reload_nxt;
    logic             tc_q, tc_nxt;
    logic [WIDTH-1:0] eff_count;

    // In IDLE a load and a start in the same cycle must judge the value being
    // loaded, not the stale count, when deciding whether there is work to do.
    assign eff_count = load_i ? load_val_i : count_q;

    always_comb begin
        state_nxt  = state;
        count_nxt  = count_q;
        reload_nxt = reload_q;
        tc_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_i) begin
                    count_nxt  = load_val_i;
                    reload_nxt = load_val_i;
                end
                if (start_i && !stop_i && (eff_count != '0))
                    state_nxt = RUN;
            end
            RUN: begin
                // Loading while running only retargets the next reload.
                if (load_i)
                    reload_nxt = load_val_i;
                if (stop_i) begin
                    state_nxt = PAUSE;
                end else if (count_q != '0) begin
                    count_nxt = count_q - 1'b1;
                    tc_nxt    = (count_q == WIDTH'(1));
                end else if (mode_i && (reload_q != '0)) begin
                    count_nxt = reload_q;
                end else begin
                    state_nxt = IDLE;
                end
            end
            PAUSE: begin
                if (load_i) begin
                    count_nxt  = load_val_i;
                    reload_nxt = load_val_i;
                end
                if (start_i && !stop_i)
                    state_nxt = (count_q != '0) ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            count_q  <= count_nxt;
            reload_q <= reload_nxt;
            tc_q     <= tc_nxt;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign busy_o  = (state == RUN);

endmodule

// File: tb/tb_day11_down_timer.sv
// tb/tb_day11_down_timer.sv - self-checking bench for day11_down_timer
module tb_day11_down_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load, start, stop, mode;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tc, busy;

    logic       load8, start8, stop8, mode8;
    logic [7:0] load_val8;
    logic [7:0] count8;
    logic       tc8, busy8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    day11_down_timer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .load_i(load), .load_val_i(load_val),
        .start_i(start), .stop_i(stop), .mode_i(mode),
        .count_o(count), .tc_o(tc), .busy_o(busy)
    );

    day11_down_timer #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .load_i(load8), .load_val_i(load_val8),
        .start_i(start8), .stop_i(stop8), .mode_i(mode8),
        .count_o(count8), .tc_o(tc8), .busy_o(busy8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: timer described as "what is it doing" plus two numbers.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
    int m_mode_st;
    int m_cnt, m_rel;
    bit m_tc;

    task automatic model_reset();
        m_mode_st = M_IDLE; m_cnt = 0; m_rel = 0; m_tc = 0;
    endtask

    task automatic model_step(input bit ld, input int val, input bit st, input bit sp, input bit md);
        int old_cnt, old_rel;
        old_cnt = m_cnt; old_rel = m_rel;
        m_tc = 0;
        if (m_mode_st == M_IDLE) begin
            if (ld) begin m_cnt = val; m_rel = val; end
            if (st && !sp && (ld ? val : old_cnt) != 0) m_mode_st = M_RUN;
        end else if (m_mode_st == M_RUN) begin
            if (ld) m_rel = val;
            if (sp) m_mode_st = M_PAUSE;
            else if (old_cnt > 0) begin
                m_cnt = old_cnt - 1;
                m_tc  = (m_cnt == 0);
            end else if (md && old_rel != 0) m_cnt = old_rel;
            else m_mode_st = M_IDLE;
        end else begin
            if (ld) begin m_cnt = val; m_rel = val; end
            if (st && !sp) m_mode_st = (old_cnt != 0) ? M_RUN : M_IDLE;
        end
    endtask

    // Called at a negedge: drive inputs, clock once, land on the next negedge.
    task automatic drive(input bit ld, input int val, input bit st, input bit sp, input bit md);
        load = ld; load_val = 4'(val); start = st; stop = sp; mode = md;
        @(posedge clk);
        model_step(ld, val, st, sp, md);
        @(negedge clk);
    endtask

    task automatic expect3(input string name, input int c, input bit t, input bit b);
        check({name, ".count"}, 32'(count), 32'(c));
        check({name, ".tc"},    32'(tc),    32'(t));
        check({name, ".busy"},  32'(busy),  32'(b));
    endtask

    typedef struct {
        bit    ld;
        int    val;
        bit    st;
        bit    sp;
        bit    md;
        int    ecnt;
        bit    etc;
        bit    ebusy;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit ld, input int val, input bit st, input bit sp, input bit md,
                       input int ecnt, input bit etc, input bit ebusy, input string name);
        vec_t v;
        v.ld = ld; v.val = val; v.st = st; v.sp = sp; v.md = md;
        v.ecnt = ecnt; v.etc = etc; v.ebusy = ebusy; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        int tc_n, tc_k, k;
        bit underflow;

        reset = 1'b0;
        load = 0; load_val = 0; start = 0; stop = 0; mode = 0;
        load8 = 0; load_val8 = 0; start8 = 0; stop8 = 0; mode8 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        expect3("reset", 0, 0, 0);
        check("reset8.count", 32'(count8), 0);
        reset = 1'b1;
        @(negedge clk);

        // ld val st sp md | count tc busy
        add(0, 0, 1, 0, 0,  0, 0, 0, "start_at_zero");
        add(1, 3, 0, 0, 0,  3, 0, 0, "load3");
        add(0, 0, 1, 0, 0,  3, 0, 1, "os_start");
        add(0, 0, 0, 0, 0,  2, 0, 1, "os_2");
        add(0, 0, 0, 0, 0,  1, 0, 1, "os_1");
        add(0, 0, 0, 0, 0,  0, 1, 1, "os_tc");
        add(0, 0, 0, 0, 0,  0, 0, 0, "os_done");
        add(0, 0, 0, 0, 0,  0, 0, 0, "os_hold0");
        add(1, 0, 1, 0, 0,  0, 0, 0, "ldstart_zero");
        add(1, 7, 1, 0, 0,  7, 0, 1, "ldstart_7");
        add(0, 0, 0, 0, 0,  6, 0, 1, "run_6");
        add(0, 0, 1, 1, 0,  6, 0, 0, "startstop_run");
        add(0, 0, 1, 1, 0,  6, 0, 0, "startstop_pause");
        add(0, 0, 1, 0, 0,  6, 0, 1, "resume");
        add(0, 0, 0, 0, 0,  5, 0, 1, "run_5");
        add(0, 0, 0, 1, 0,  5, 0, 0, "stop_5");
        add(1, 1, 0, 0, 0,  1, 0, 0, "pause_load1");
        add(0, 0, 1, 0, 0,  1, 0, 1, "resume_1");
        add(0, 0, 0, 0, 0,  0, 1, 1, "tc_from_1");
        add(0, 0, 0, 0, 0,  0, 0, 0, "idle_again");
        add(1, 4, 1, 1, 0,  4, 0, 0, "idle_stop_blocks");
        add(0, 0, 0, 1, 0,  4, 0, 0, "idle_stop_ignored");

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].val, vecs[i].st, vecs[i].sp, vecs[i].md);
            expect3(vecs[i].name, vecs[i].ecnt, vecs[i].etc, vecs[i].ebusy);
        end

        // Auto-reload with reload 2: period 3, then retarget to 4 mid-descent.
        drive(1, 2, 1, 0, 1);
        expect3("ar_start", 2, 0, 1);
        for (int j = 1; j <= 6; j++) begin
            drive(0, 0, 0, 0, 1);
            expect3($sformatf("ar_k%0d", j), 2 - (j % 3), (j % 3) == 2, 1);
        end
        drive(1, 4, 0, 0, 1);
        expect3("ar_ld4_cur", 1, 0, 1);
        drive(0, 0, 0, 0, 1);
        expect3("ar_ld4_tc", 0, 1, 1);
        drive(0, 0, 0, 0, 1);
        expect3("ar_ld4_rel", 4, 0, 1);
        drive(0, 0, 0, 0, 1);
        expect3("ar_ld4_3", 3, 0, 1);
        drive(0, 0, 0, 1, 0);
        expect3("ar_stop", 3, 0, 0);

        // Pause at 3 for 4 cycles, then resume.
        drive(1, 5, 0, 0, 0);
        expect3("p_load5", 5, 0, 0);
        drive(0, 0, 1, 0, 0);
        expect3("p_start", 5, 0, 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        expect3("p_at3", 3, 0, 1);
        for (int j = 0; j < 4; j++) begin
            drive(0, 0, 0, 1, 0);
            expect3($sformatf("p_hold%0d", j), 3, 0, 0);
        end
        drive(0, 0, 1, 0, 0);
        expect3("p_resume", 3, 0, 1);
        drive(0, 0, 0, 0, 0);
        expect3("p_2", 2, 0, 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        expect3("p_tc", 0, 1, 1);
        drive(0, 0, 0, 0, 0);
        expect3("p_idle", 0, 0, 0);

        // Asynchronous reset in the middle of a run at count 5.
        drive(1, 7, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        expect3("rst_pre", 5, 0, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 expect3("rst_async", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        drive(0, 0, 1, 0, 0);
        expect3("rst_start_only", 0, 0, 0);

        // Randomised run against the model.
        for (int j = 0; j < 600; j++) begin
            bit ld, st, sp, md;
            int val;
            ld  = ($urandom_range(0, 7) == 0);
            st  = ($urandom_range(0, 3) == 0);
            sp  = ($urandom_range(0, 9) == 0);
            md  = $urandom_range(0, 1);
            val = $urandom_range(0, 15);
            drive(ld, val, st, sp, md);
            expect3($sformatf("rnd%0d", j), m_cnt, m_tc, m_mode_st == M_RUN);
        end

        // WIDTH=8 full-range one-shot: 255 down to 0 with a single pulse.
        load8 = 1; load_val8 = 8'd255; start8 = 1; mode8 = 0;
        @(posedge clk); @(negedge clk);
        load8 = 0; start8 = 0;
        check("w8_start.count", 32'(count8), 255);
        check("w8_start.busy", 32'(busy8), 1);
        tc_n = 0; tc_k = -1; underflow = 0;
        for (k = 1; k <= 300; k++) begin
            @(posedge clk); @(negedge clk);
            if (tc8) begin tc_n++; tc_k = k; end
            if (count8 == 8'd255) underflow = 1;
        end
        check("w8_tc_pulses", 32'(tc_n), 1);
        check("w8_tc_edge", 32'(tc_k), 255);
        check("w8_underflow", 32'(underflow), 0);
        check("w8_end.count", 32'(count8), 0);
        check("w8_end.busy", 32'(busy8), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
